// File: rtl/cm0_core_smul_seq_if.sv
// Handshake and data bundle between the core issue logic and the small-multiplier
// sequencer. The bit-select mux index (imm_o) and its returned bit (sel_i) travel
// here as well, so the sequencer sees one bus for everything except clock and reset.
interface cm0_core_smul_seq_if;
    logic        start_i;
    logic        kill_i;
    logic [31:0] opb_i;
    logic        sel_i;
    logic [4:0]  imm_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] res_o;

    // Issue logic / mux side
    modport master (
        output start_i, kill_i, opb_i, sel_i,
        input  imm_o, busy_o, done_o, res_o
    );

    // Sequencer side
    modport slave (
        input  start_i, kill_i, opb_i, sel_i,
        output imm_o, busy_o, done_o, res_o
    );
endinterface

// File: rtl/cm0_core_smul_seq.sv
// Iterative MSB-first shift-and-add sequencer for the small-multiplier MULS path.
// Each RUN cycle it selects one multiplier bit through the external 32:1 mux
// (imm 1..31 -> bits 31..1, imm 0 -> bit 0) and folds it into the accumulator.
// 33 cycles from accepted start to the done pulse; low 32 bits of the product only.
module cm0_core_smul_seq #(
    parameter bit SMUL = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cm0_core_smul_seq_if.slave    bus
);

    generate
        if (SMUL) begin : g_seq
            typedef enum logic [1:0] {
                ST_IDLE = 2'd0,
                ST_RUN  = 2'd1,
                ST_DONE = 2'd2
            } state_t;

            state_t      r_state;
            state_t      w_state_nxt;
            logic [4:0]  r_cnt;
            logic [31:0] r_acc;
            logic [31:0] r_opb_q;
            logic [31:0] r_res_q;
            logic        w_accept;
            logic [31:0] w_acc_nxt;

            // A new operation may start only from IDLE or DONE; kill always wins.
            assign w_accept  = bus.start_i && !bus.kill_i &&
                               ((r_state == ST_IDLE) || (r_state == ST_DONE));
            // Shift-and-add step; the sum deliberately wraps modulo 2^32.
            assign w_acc_nxt = (r_acc << 1) + (bus.sel_i ? r_opb_q : 32'd0);

            // State register.
            always_ff @(posedge clk_i) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // register samples pre-edge values regardless of block ordering.
                if (rst_i) r_state <= ST_IDLE;
                else       r_state <= w_state_nxt;
            end

            // Next-state decode.
            always_comb begin
                // NOTE: default assigned first so no path leaves the output
                // unassigned, which would otherwise infer a latch.
                w_state_nxt = r_state;
                if (bus.kill_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    case (r_state)
                        ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
                        ST_RUN:  if (r_cnt == 5'd0) w_state_nxt = ST_DONE;
                        ST_DONE: w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end
            end

            // Datapath: operand capture, accumulate, step count, result latch.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt   <= 5'd0;
                    r_acc   <= 32'd0;
                    r_opb_q <= 32'd0;
                    r_res_q <= 32'd0;
                end else if (bus.kill_i) begin
                    // Abort: scratch state cleared, last good result kept.
                    r_cnt <= 5'd0;
                    r_acc <= 32'd0;
                end else if (w_accept) begin
                    r_opb_q <= bus.opb_i;
                    r_acc   <= 32'd0;
                    r_cnt   <= 5'd1;
                end else if (r_state == ST_RUN) begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    // cnt==0 is the bit-0 step, the last one of the product.
                    if (r_cnt == 5'd0) r_res_q <= w_acc_nxt;
                end
            end

            // Outputs decode registered state only.
            always_comb begin
                bus.imm_o  = (r_state == ST_RUN) ? r_cnt : 5'd0;
                bus.busy_o = (r_state == ST_RUN);
                bus.done_o = (r_state == ST_DONE);
                bus.res_o  = r_res_q;
            end
        end else begin : g_tieoff
            // Fast-multiplier build: sequencer absent, outputs constant.
            assign bus.imm_o  = 5'd0;
            assign bus.busy_o = 1'b0;
            assign bus.done_o = 1'b0;
            assign bus.res_o  = 32'd0;
        end
    endgenerate

endmodule

// File: tb/tb_cm0_core_smul_seq.sv
// Directed bench for cm0_core_smul_seq. The multiplier bit-select mux is modelled
// combinationally from the multiplier operand ra; expected products are hand-computed.
module tb_cm0_core_smul_seq;

    logic        clk;
    logic        rst;
    logic [31:0] ra;
    int          checks;
    int          errors;

    cm0_core_smul_seq_if bus ();

    cm0_core_smul_seq #(.SMUL(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Bit-select mux model: imm 0 -> ra[0], imm k -> ra[32-k].
    assign bus.sel_i = (bus.imm_o == 5'd0) ? ra[0] : ra[32 - int'(bus.imm_o)];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full operation with per-cycle checks of imm/busy/done, then result and hold.
    task automatic run_mul(input string tag, input logic [31:0] ra_v,
                           input logic [31:0] rb_v, input logic [31:0] exp);
        ra          = ra_v;
        bus.opb_i   = rb_v;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            check({tag, " imm"},  {27'd0, bus.imm_o}, (c == 32) ? 32'd0 : 32'(c));
            check({tag, " busy"}, {31'd0, bus.busy_o}, 32'd1);
            check({tag, " done"}, {31'd0, bus.done_o}, 32'd0);
            step();
        end
        check({tag, " done C33"}, {31'd0, bus.done_o}, 32'd1);
        check({tag, " busy C33"}, {31'd0, bus.busy_o}, 32'd0);
        check({tag, " imm C33"},  {27'd0, bus.imm_o}, 32'd0);
        check({tag, " res C33"},  bus.res_o, exp);
        step();
        check({tag, " done C34"}, {31'd0, bus.done_o}, 32'd0);
        check({tag, " res held"}, bus.res_o, exp);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        ra          = 32'd0;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.opb_i   = 32'd0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("reset imm",  {27'd0, bus.imm_o}, 32'd0);
        check("reset busy", {31'd0, bus.busy_o}, 32'd0);
        check("reset done", {31'd0, bus.done_o}, 32'd0);
        check("reset res",  bus.res_o, 32'd0);

        // Basic and boundary products
        run_mul("3x5",      32'd3,          32'd5,          32'h0000_000F);
        run_mul("m1xm1",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001);
        run_mul("m2x7",     32'hFFFF_FFFE,  32'd7,          32'hFFFF_FFF2);
        run_mul("ovf",      32'h0001_0000,  32'h0001_0000,  32'h0000_0000);
        run_mul("zero",     32'd0,          32'h1234_5678,  32'h0000_0000);

        // Abort: complete 3x5, start 6x7, kill in C10
        run_mul("pre-kill", 32'd3, 32'd5, 32'h0000_000F);
        ra          = 32'd6;
        bus.opb_i   = 32'd7;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int c = 1; c < 10; c++) step();
        check("kill busy C10", {31'd0, bus.busy_o}, 32'd1);
        bus.kill_i = 1'b1;
        step();
        bus.kill_i = 1'b0;
        check("kill busy", {31'd0, bus.busy_o}, 32'd0);
        check("kill imm",  {27'd0, bus.imm_o}, 32'd0);
        check("kill res",  bus.res_o, 32'h0000_000F);
        for (int c = 0; c < 30; c++) begin
            check("kill no done", {31'd0, bus.done_o}, 32'd0);
            step();
        end
        check("kill res later", bus.res_o, 32'h0000_000F);
        bus.start_i = 1'b1;
        bus.kill_i  = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        check("kill+start busy", {31'd0, bus.busy_o}, 32'd0);
        step();
        check("kill+start busy2", {31'd0, bus.busy_o}, 32'd0);

        // Back-to-back with an ignored mid-run start: 2x9 then 4x4
        ra          = 32'd2;
        bus.opb_i   = 32'd9;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (c == 15) begin
                bus.opb_i   = 32'hDEAD_BEEF;
                bus.start_i = 1'b1;
            end else begin
                bus.start_i = 1'b0;
            end
            step();
        end
        bus.start_i = 1'b0;
        check("b2b done C33", {31'd0, bus.done_o}, 32'd1);
        check("b2b res C33",  bus.res_o, 32'h0000_0012);
        ra          = 32'd4;
        bus.opb_i   = 32'd4;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        check("b2b busy C34", {31'd0, bus.busy_o}, 32'd1);
        check("b2b imm C34",  {27'd0, bus.imm_o}, 32'd1);
        check("b2b res C34",  bus.res_o, 32'h0000_0012);
        for (int c = 34; c < 66; c++) begin
            check("b2b no done", {31'd0, bus.done_o}, 32'd0);
            step();
        end
        check("b2b done C66", {31'd0, bus.done_o}, 32'd1);
        check("b2b res C66",  bus.res_o, 32'h0000_0010);
        step();

        // Reset mid-operation at C20 of 6x7
        ra          = 32'd6;
        bus.opb_i   = 32'd7;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int c = 1; c < 20; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst imm",  {27'd0, bus.imm_o}, 32'd0);
        check("rst busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst done", {31'd0, bus.done_o}, 32'd0);
        check("rst res",  bus.res_o, 32'd0);
        for (int c = 0; c < 20; c++) begin
            check("rst no done", {31'd0, bus.done_o}, 32'd0);
            step();
        end
        run_mul("6x7", 32'd6, 32'd7, 32'h0000_002A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
